// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid pipeline register.
//   PIPE_WIDTH   default data path width
//   pipe_state_e occupancy state of the skid register (EMPTY, ONE, TWO)
//   state_count  maps a state onto the number of held words
package pipe_pkg;

    localparam int unsigned PIPE_WIDTH = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] state_count(input pipe_state_e st);
        logic [1:0] cnt;
        case (st)
            EMPTY:   cnt = 2'd0;
            ONE:     cnt = 2'd1;
            TWO:     cnt = 2'd2;
            default: cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/flopenr.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
//   clk   rising-edge clock
//   reset synchronous reset, clears q to zero
//   en    load d into q on the next edge
//   d     next value
//   q     registered value
module flopenr #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage: reset wins, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register. Breaks the ready path between upstream
// and downstream while sustaining one word per cycle. out_data is always the
// main register; the skid register catches the word accepted while the
// downstream stalls.
//   clk       rising-edge clock
//   reset     synchronous active-high reset (priority over everything)
//   in_valid  / in_ready / in_data    upstream handshake
//   flush     synchronous discard of all held words
//   out_valid / out_ready / out_data  downstream handshake
//   count     number of held words (0..2)
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    pipe_state_e      state_r;
    pipe_state_e      next_state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [1:0]       count_r;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             main_en_s;
    logic             skid_en_s;
    logic             main_sel_skid_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;
    assign main_d_s   = main_sel_skid_s ? skid_q_s : in_data;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign out_data  = main_q_s;

    // Next state and register load controls; flush suppresses all loads.
    always_comb begin
        next_state_s    = state_r;
        main_en_s       = 1'b0;
        skid_en_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (in_xfer_s) begin
                    main_en_s    = 1'b1;
                    next_state_s = ONE;
                end else begin
                    next_state_s = EMPTY;
                end
            end
            ONE: begin
                if (in_xfer_s && !out_xfer_s) begin
                    skid_en_s    = 1'b1;
                    next_state_s = TWO;
                end else if (!in_xfer_s && out_xfer_s) begin
                    next_state_s = EMPTY;
                end else if (in_xfer_s && out_xfer_s) begin
                    // Pass-through: the new word replaces the departing one.
                    main_en_s    = 1'b1;
                    next_state_s = ONE;
                end else begin
                    next_state_s = ONE;
                end
            end
            TWO: begin
                if (out_xfer_s) begin
                    main_en_s       = 1'b1;
                    main_sel_skid_s = 1'b1;
                    next_state_s    = ONE;
                end else begin
                    next_state_s = TWO;
                end
            end
            default: begin
                next_state_s = EMPTY;
            end
        endcase
        if (flush) begin
            next_state_s    = EMPTY;
            main_en_s       = 1'b0;
            skid_en_s       = 1'b0;
            main_sel_skid_s = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State register; handshake outputs are registered copies decoded from
    // the next state so they never depend combinationally on any input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            count_r     <= 2'd0;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= (next_state_s != EMPTY);
            in_ready_r  <= (next_state_s != TWO);
            count_r     <= state_count(next_state_s);
        end
    end

    flopenr #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    flopenr #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en_s),
        .d     (in_data),
        .q     (skid_q_s)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int checks = 0;
    int failures = 0;

    // Reference: the ordered list of words the block should be holding.
    logic [W-1:0] exp_q[$];
    logic         zero_data = 1'b1;
    logic         armed = 1'b0;
    logic         pop_req = 1'b0;

    pipe_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, then record what the block should accept.
    task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        pop_req = 1'b0;
        if (rst) begin
            exp_q.delete();
            zero_data = 1'b1;
        end else if (fl) begin
            exp_q.delete();
            zero_data = 1'b0;
        end else begin
            if (out_valid && out_ready) pop_req = 1'b1;
            if (v && in_ready) begin
                exp_q.push_back(d);
                zero_data = 1'b0;
            end
        end
    endtask

    // Monitor: state checks at each falling edge, then pop and compare the
    // departing word when an output transfer is about to happen.
    always begin
        @(negedge clk);
        if (armed) begin
            chk("count", {62'd0, count}, W'(exp_q.size()));
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
            if (exp_q.size() != 0) chk("out_data_head", out_data, exp_q[0]);
            else if (zero_data) chk("out_data_reset", out_data, '0);
        end
        #2;
        if (armed && pop_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_empty: output transfer with nothing expected at %0t", $time);
            end else begin
                chk("scoreboard_pop", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset held 5 cycles with a word offered.
        step(1'b1, 64'h5, 1'b0, 1'b0, 1'b1);
        armed = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 64'h5, 1'b0, 1'b0, 1'b1);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

        // Streaming 0x1..0xA at full rate.
        for (int i = 1; i <= 10; i++) step(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure: fill with 0xA, 0xB; 0xC waits; then drain.
        step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Flush from TWO with a same-edge input of 0x9.
        step(1'b1, 64'h7, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h8, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h9, 1'b1, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Simultaneous in/out while holding one word.
        step(1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h4, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Reset from TWO with downstream ready, then a fresh word.
        step(1'b1, 64'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 2);
        end

        // Drain and make sure every accepted word came out.
        for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("drained", W'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
